// File: rtl/pulse_train_sequencer_if.sv
// Control/serializer-side signal bundle for the pulse train sequencer.
// master = control register block + serializer side; slave = sequencer.
interface pulse_train_sequencer_if;
    logic        start_i;
    logic [10:0] pulse_width_i;
    logic [10:0] pulse_num_i;
    logic [15:0] gap_us_i;
    logic        abort_i;
    logic [7:0]  word_o;
    logic        busy_o;
    logic        done_o;
    logic [10:0] pulse_cnt_o;

    modport master (
        output start_i, pulse_width_i, pulse_num_i, gap_us_i, abort_i,
        input  word_o, busy_o, done_o, pulse_cnt_o
    );

    modport slave (
        input  start_i, pulse_width_i, pulse_num_i, gap_us_i, abort_i,
        output word_o, busy_o, done_o, pulse_cnt_o
    );
endinterface

// File: rtl/pulse_train_sequencer.sv
// Builds per-cycle parallel words for an 8:1 DDR serializer so the output pin
// carries a train of pulses of configurable width, count and microsecond gap.
module pulse_train_sequencer #(
    parameter int unsigned CLK_PER_US = 125,
    parameter int unsigned WORD_W     = 8
) (
    input logic                    clk,
    input logic                    rst,
    pulse_train_sequencer_if.slave bus
);

    typedef enum logic [2:0] {StIdle, StHigh, StTail, StGap, StDone} state_e;

    localparam logic [7:0]        PreMax  = 8'(CLK_PER_US - 1);
    localparam logic [WORD_W-1:0] AllOnes = '1;

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [10:0]         cnt_q, cnt_d;
    logic [7:0]          wcnt_q, wcnt_d;
    logic [7:0]          pre_q, pre_d;
    logic [15:0]         us_q, us_d;
    logic [10:0]         width_q, width_d;
    logic [10:0]         num_q, num_d;
    logic [15:0]         gap_q, gap_d;
    logic                pulse_begin, pulse_end;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wcnt_d      = wcnt_q;
        pre_d       = pre_q;
        us_d        = us_q;
        width_d     = width_q;
        num_d       = num_q;
        gap_d       = gap_q;
        pulse_begin = 1'b0;
        pulse_end   = 1'b0;
        word_d      = '0;
        busy_d      = 1'b0;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start_i && !bus.abort_i) begin
                    width_d = bus.pulse_width_i;
                    num_d   = bus.pulse_num_i;
                    gap_d   = bus.gap_us_i;
                    cnt_d   = '0;
                    if (bus.pulse_width_i == '0 || bus.pulse_num_i == '0) begin
                        state_d = StDone;
                    end else begin
                        pulse_begin = 1'b1;
                    end
                end
            end
            StHigh: begin
                // wcnt_q counts FF words emitted including the current one
                if (wcnt_q == width_q[10:3]) begin
                    if (width_q[2:0] != '0) state_d = StTail;
                    else                    pulse_end = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + 8'd1;
                end
            end
            StTail: pulse_end = 1'b1;
            StGap: begin
                if (gap_q == '0 || (us_q == gap_q - 16'd1 && pre_q == PreMax)) begin
                    pulse_begin = 1'b1;
                end else if (pre_q == PreMax) begin
                    pre_d = '0;
                    us_d  = us_q + 16'd1;
                end else begin
                    pre_d = pre_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (pulse_end) begin
            cnt_d   = cnt_q + 11'd1;
            state_d = (cnt_d == num_q) ? StDone : StGap;
            pre_d   = '0;
            us_d    = '0;
        end

        if (pulse_begin) begin
            if (width_d[10:3] != '0) begin
                state_d = StHigh;
                wcnt_d  = 8'd1;
            end else begin
                state_d = StTail;
            end
        end

        // Abort overrides any pulse completion happening in the same cycle
        if (bus.abort_i && (state_q == StHigh || state_q == StTail || state_q == StGap)) begin
            state_d = StIdle;
            cnt_d   = cnt_q;
        end

        unique case (state_d)
            StHigh:  word_d = AllOnes;
            StTail:  word_d = ~(AllOnes << width_d[2:0]);
            default: word_d = '0;
        endcase
        busy_d = (state_d == StHigh) || (state_d == StTail) || (state_d == StGap);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            word_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            pre_q   <= '0;
            us_q    <= '0;
            width_q <= '0;
            num_q   <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
            pre_q   <= pre_d;
            us_q    <= us_d;
            width_q <= width_d;
            num_q   <= num_d;
            gap_q   <= gap_d;
        end
    end

    assign bus.word_o      = word_q;
    assign bus.busy_o      = busy_q;
    assign bus.done_o      = done_q;
    assign bus.pulse_cnt_o = cnt_q;

endmodule
